// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder and its dump streamer.
package data_mem_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int IDX_W         = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor port and dump stream of the data memory responder, plus FSM debug state.
// Dump stream handshake: a word transfers on a rising edge where dump_valid && dump_ready;
// while dump_valid=1 and dump_ready=0, dump_addr/dump_data hold stable.
interface data_mem_responder_if #(parameter int ADDR_W = 32) ();
    import data_mem_pkg::*;

    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] memoryOut;
    logic              memoryWE;
    logic [DATA_W-1:0] memoryIn;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [IDX_W-1:0]  dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;
    logic              addr_err;
    dump_state_e       dump_state;

    modport slave (
        input  memoryAddress, memoryOut, memoryWE, dump_start, dump_ready,
        output memoryIn, dump_valid, dump_addr, dump_data, dump_busy, dump_done,
        output addr_err, dump_state
    );

    modport master (
        output memoryAddress, memoryOut, memoryWE, dump_start, dump_ready,
        input  memoryIn, dump_valid, dump_addr, dump_data, dump_busy, dump_done,
        input  addr_err, dump_state
    );

endinterface

// File: rtl/data_mem_responder_dump_streamer.sv
// Dump engine: walks indices 0..DEPTH-1, registering each word as it is offered.
module dump_streamer
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] load_word,
    output logic [IDX_W-1:0]  load_idx,
    output logic              dump_valid,
    output logic [IDX_W-1:0]  dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done,
    output dump_state_e       state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dump_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // load_idx names the word the top must supply (with write bypass) this cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        load_idx = idx_q + IDX_W'(1);
        case (state_q)
            DUMP_IDLE: begin
                load_idx = '0;
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                    data_d  = load_word;
                end
            end
            DUMP_SEND: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DUMP_DONE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = load_word;
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    assign dump_valid = (state_q == DUMP_SEND);
    assign dump_done  = (state_q == DUMP_DONE);
    assign dump_busy  = (state_q != DUMP_IDLE);
    assign dump_addr  = idx_q;
    assign dump_data  = data_q;
    assign state      = state_q;

endmodule

// File: rtl/data_mem_responder.sv
// Zero-latency data memory with a handshaked dump stream of all words.
// Optional DATA_MEM_BOUNDS_CHECK_EN: out-of-range addresses are rejected and flagged.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  widx;
    logic              in_range;
    logic              wr_en;
    logic [IDX_W-1:0]  load_idx;
    logic [DATA_W-1:0] load_word;

    assign addr = bus.memoryAddress;
    assign widx = addr[IDX_W-1:0];

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    assign in_range = (addr < ADDR_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset)
            bus.addr_err <= 1'b0;
        else if (bus.memoryWE && !in_range)
            bus.addr_err <= 1'b1;
    end
`else
    // Upper address bits are discarded: addresses wrap modulo the word count.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
    assign in_range       = 1'b1;
    assign bus.addr_err   = 1'b0;
`endif

    assign wr_en        = bus.memoryWE && in_range;
    assign bus.memoryIn = in_range ? mem[widx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[widx] <= bus.memoryOut;
        end
    end

    // A same-cycle write to the word being loaded wins over the stored value.
    assign load_word = (wr_en && (widx == load_idx)) ? bus.memoryOut : mem[load_idx];

    dump_streamer #(.DEPTH(DEPTH)) u_streamer (
        .clk        (clk),
        .reset      (reset),
        .dump_start (bus.dump_start),
        .dump_ready (bus.dump_ready),
        .load_word  (load_word),
        .load_idx   (load_idx),
        .dump_valid (bus.dump_valid),
        .dump_addr  (bus.dump_addr),
        .dump_data  (bus.dump_data),
        .dump_busy  (bus.dump_busy),
        .dump_done  (bus.dump_done),
        .state      (bus.dump_state)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(32)) bus ();

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [36:0] exp_q [$];
    logic [31:0] rd_q [$];
    logic        rd_chk = 1'b0;
    bit          mon_en = 1'b0;
    bit          exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;

    logic [31:0] m_mem [DEPTH];
    int          m_phase = 0;
    int          m_idx = 0;
    bit          m_err = 1'b0;
    bit          m_flush = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_in_range(logic [31:0] a);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
        return a < 32'(DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int m_widx(logic [31:0] a);
        return int'(a % 32'(DEPTH));
    endfunction

    task automatic push_word(input int k);
        exp_q.push_back({5'(k), m_mem[k]});
    endtask

    // One clock of stimulus; the model advances to the state after the coming edge.
    task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic start, input logic rdy, input logic chk, input logic rst);
        @(posedge clk);
        #1;
        if (m_flush) begin
            exp_q.delete();
            m_flush = 1'b0;
        end
        exp_valid = (m_phase == 1);
        exp_done  = (m_phase == 2);
        exp_busy  = (m_phase != 0);
        exp_err   = m_err;
        reset              = rst;
        bus.memoryAddress  = a;
        bus.memoryWE       = we;
        bus.memoryOut      = wd;
        bus.dump_start     = start;
        bus.dump_ready     = rdy;
        rd_chk             = chk;
        if (chk) rd_q.push_back(m_in_range(a) ? m_mem[m_widx(a)] : 32'h0);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            m_phase = 0;
            m_idx   = 0;
            m_err   = 1'b0;
            m_flush = 1'b1;
        end else begin
            if (we) begin
                if (m_in_range(a)) m_mem[m_widx(a)] = wd;
                else m_err = 1'b1;
            end
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_idx   = 0;
                    push_word(0);
                end
                1: if (rdy) begin
                    if (m_idx == DEPTH - 1) begin
                        m_phase = 2;
                    end else begin
                        m_idx++;
                        push_word(m_idx);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(32'h0, 1'b0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("dump_valid", 64'(bus.dump_valid), 64'(exp_valid));
            check("dump_done", 64'(bus.dump_done), 64'(exp_done));
            check("dump_busy", 64'(bus.dump_busy), 64'(exp_busy));
            check("addr_err", 64'(bus.addr_err), 64'(exp_err));
            if (rd_chk) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_q: read checked with no expectation at %0t", $time);
                end else begin
                    check("memoryIn", 64'(bus.memoryIn), 64'(rd_q.pop_front()));
                end
            end
            if (exp_valid && bus.dump_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dump_word: word offered with none expected, got %0h_%0h",
                             bus.dump_addr, bus.dump_data);
                end else begin
                    check("dump_word", 64'({bus.dump_addr, bus.dump_data}), 64'(exp_q[0]));
                    if (bus.dump_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        bus.memoryAddress = '0;
        bus.memoryWE      = 1'b0;
        bus.memoryOut     = '0;
        bus.dump_start    = 1'b0;
        bus.dump_ready    = 1'b0;

        // Reset, with write and dump_start asserted to confirm reset priority.
        step(32'h0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_dump_data", 64'(bus.dump_data), 64'h0);
        check("reset_dump_addr", 64'(bus.dump_addr), 64'h0);
        check("reset_mem0", 64'(bus.memoryIn), 64'h0);

        // Write-then-read: old value in write cycle, new value after.
        step(32'd0, 1'b1, 32'd13, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill i*3 and stream everything with ready held high.
        for (int i = 0; i < DEPTH; i++) step(32'(i), 1'b1, 32'(i * 3), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(32'($urandom_range(0, 31)), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(34, 1'b1);

        // Stall at index 7 while overwriting 7; write 8 in the accepting cycle.
        step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(7, 1'b1);
        repeat (5) step(32'd7, 1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'd8, 1'b1, 32'h888, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(30, 1'b1);

        // Random traffic: random ready, writes, reads and ignored/extra start pulses.
        step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 200; k++) begin
            step(32'($urandom_range(0, 63)), 1'($urandom_range(0, 9) < 3), $urandom,
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        idle(40, 1'b1);

        // Reset in the middle of a dump at index 10.
        step(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10, 1'b1);
        step(32'd3, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(32'(i), 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Out-of-range write to address 33.
        step(32'd33, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'd33, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'h0);
        check("rd_q_drained", 64'(rd_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 32, number of 32-bit data words.
REQ-002 Parameter: ADDR_W, 32, width of processor address.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: memoryAddress  input  ADDR_W  processor word address.
REQ-006 Port: memoryOut  input  32  processor write data.
REQ-007 Port: memoryWE  input  1  processor write enable.
REQ-008 Port: memoryIn  output  32  read data returned to processor.
REQ-009 Port: dump_start  input  1  one-cycle request to stream all words out.
REQ-010 Port: dump_ready  input  1  consumer accepts the current dump word.
REQ-011 Port: dump_valid  output  1  dump word on dump_addr/dump_data is valid.
REQ-012 Port: dump_addr  output  5  index of the offered word.
REQ-013 Port: dump_data  output  32  offered word, registered.
REQ-014 Port: dump_busy  output  1  dump engine not IDLE.
REQ-015 Port: dump_done  output  1  one-cycle pulse after last word accepted.
REQ-016 Port: addr_err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-017 memoryIn SHALL equal mem[memoryAddress] combinationally, zero latency.
REQ-018 When memoryWE=1, mem[memoryAddress] SHALL take memoryOut at the rising edge; read in the same cycle returns the old value.
REQ-019 Dump FSM states: IDLE, SEND, DONE.
REQ-020 IDLE + dump_start=1 -> SEND, index=0, dump_data loaded with mem[0].
REQ-021 SEND: dump_valid=1; dump_addr, dump_data SHALL hold stable while dump_ready=0.
REQ-022 SEND + dump_ready=1 and index<DEPTH-1 -> index+1, dump_data loaded with the next word, same cycle.
REQ-023 SEND + dump_ready=1 and index=DEPTH-1 -> DONE; DONE lasts exactly one cycle with dump_done=1, then IDLE.
REQ-024 dump_start SHALL be ignored outside IDLE.
REQ-025 Load bypass: if memoryWE=1 and memoryAddress equals the word being loaded into dump_data, the loaded value SHALL be memoryOut.
REQ-026 A processor write to an already-loaded, not-yet-accepted word SHALL NOT change dump_data.
REQ-027 Processor access SHALL never stall; the dump engine never blocks writes.
REQ-028 dump_busy=1 in SEND and DONE.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE and clear index, dump_valid, dump_done, dump_data, dump_addr, and addr_err to 0.
REQ-030 reset SHALL clear all DEPTH words to 0; a dump in progress is aborted with no dump_done.
REQ-031 reset SHALL take priority over memoryWE and dump_start in the same cycle.

Configuration
REQ-032 Macro DATA_MEM_BOUNDS_CHECK_EN defined: address >= DEPTH SHALL suppress the write, return 0 on memoryIn, and set addr_err until reset.
REQ-033 Macro undefined: address SHALL be taken modulo DEPTH (low 5 bits), and addr_err SHALL be tied to 0.

Structure
REQ-034 Shared package data_mem_pkg: dump FSM state enum, DEPTH default, data width constant.
REQ-035 One sub-module, dump_streamer (FSM, index counter, dump_data register); storage and processor port stay in the top level.

Verification
REQ-036 Write 13 to address 0, then read address 0 -> memoryIn=13 the cycle after the write edge, and the old value in the write cycle.
REQ-037 Fill words i=i*3, assert dump_start with dump_ready=1 -> 32 consecutive valid words 0,3,...,93, then dump_done for one cycle, then IDLE.
REQ-038 During a dump, hold dump_ready=0 for 5 cycles at index 7 while writing address 7 -> dump_data stays the old value; writing address 8 in the accept cycle -> word 8 delivered with the new value.
REQ-039 Assert reset at index 10 of a dump -> next cycle dump_valid=0, dump_busy=0, no dump_done, all words read as 0.
REQ-040 Write 0xAA to address 33 -> with DATA_MEM_BOUNDS_CHECK_EN, no write occurs and addr_err=1 stays set; without it, address 1 becomes 0xAA.
